weight_fetch_arbiter: RTL and testbench

Arbitrates burst weight reads from several neuron units onto the single shared `Weight_ROM` port. The arbiter grants one requester at a time and drives the ROM `address`/`enable`. It registers the ROM data and streams it back to the winner with valid/last framing, one word per cycle. The block sits between the neuron layer controllers and the weight ROM, and is the only driver of the ROM's address and enable.

---
 rtl/weight_fetch_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_weight_fetch_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_arbiter.sv
// weight_fetch_arbiter
//
// Arbitrates burst reads from NUM_REQ neuron units onto the single shared weight ROM port.
// One requester is granted at a time; the arbiter walks the ROM address from the winner's base
// for the winner's length, registers each ROM word and streams it back with valid/last framing.
//
// Arbitration:
//   WEIGHT_FETCH_RR_EN defined   -> round-robin from a priority pointer that advances past the
//                                   last owner at the end of every burst.
//   WEIGHT_FETCH_RR_EN undefined -> fixed priority, lowest requesting index wins.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_i           per-requester request level, held until the matching done_o pulse
//   req_base_i      packed start addresses, requester i at [i*AW +: AW]
//   req_len_i       packed burst lengths,   requester i at [i*LW +: LW]
//   grant_o         one-hot owner, high only while fetching
//   rd_data_o       registered ROM word
//   rd_valid_o      rd_data_o valid this cycle
//   rd_last_o       final word of the burst
//   done_o          one-cycle pulse to the burst owner at burst end
//   busy_o          arbiter not idle
//   rom_address_o   ROM address, 0 when not fetching
//   rom_enable_o    ROM enable, high only while fetching
//   rom_data_i      combinational ROM data for the current address

module weight_fetch_arbiter #(
    parameter int unsigned DATA_BUS_WIDTH    = 8,
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned LEN_WIDTH         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ*ADDRESS_BUS_WIDTH-1:0] req_base_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]         req_len_i,
    output logic [NUM_REQ-1:0]                   grant_o,
    output logic [DATA_BUS_WIDTH-1:0]            rd_data_o,
    output logic                                 rd_valid_o,
    output logic                                 rd_last_o,
    output logic [NUM_REQ-1:0]                   done_o,
    output logic                                 busy_o,
    output logic [ADDRESS_BUS_WIDTH-1:0]         rom_address_o,
    output logic                                 rom_enable_o,
    input  logic [DATA_BUS_WIDTH-1:0]            rom_data_i
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDone
    } state_e;

    state_e                         state_q;
    logic [LEN_WIDTH-1:0]           cnt_q;
    logic [ADDRESS_BUS_WIDTH-1:0]   rom_address_q;
    logic                           rom_enable_q;
    logic [NUM_REQ-1:0]             grant_q;
    logic [DATA_BUS_WIDTH-1:0]      rd_data_q;
    logic                           rd_valid_q;
    logic                           rd_last_q;
    logic [NUM_REQ-1:0]             done_q;

    // Unpacked views of the packed request fields.
    logic [ADDRESS_BUS_WIDTH-1:0]   base_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]           len_arr  [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            base_arr[i] = req_base_i[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
            len_arr[i]  = req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    // Winner selection
    logic                 any_req;
    logic [IdxW-1:0]      win_idx;
    logic [NUM_REQ-1:0]   win_onehot;

`ifdef WEIGHT_FETCH_RR_EN
    logic [IdxW-1:0]      ptr_q;
    logic [IdxW-1:0]      owner_q;
    logic [IdxW-1:0]      cand_idx;
    logic [IdxW-1:0]      ptr_next;

    // First set request at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        any_req  = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_idx = IdxW'((32'(ptr_q) + k) % NUM_REQ);
            if (!any_req && req_i[cand_idx]) begin
                any_req = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_next = '0;
        if (32'(owner_q) != NUM_REQ - 1) begin
            ptr_next = owner_q + IdxW'(1);
        end
    end
`else
    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_req = 1'b1;
                win_idx = IdxW'(i);
            end
        end
    end
`endif

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

    // Control FSM with registered outputs. rom_address_q doubles as the address counter and is
    // forced to 0 whenever the FSM leaves FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rom_address_q <= '0;
            rom_enable_q  <= 1'b0;
            grant_q       <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            done_q        <= '0;
`ifdef WEIGHT_FETCH_RR_EN
            ptr_q         <= '0;
            owner_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                    done_q     <= '0;
                    if (any_req) begin
                        cnt_q <= len_arr[win_idx];
`ifdef WEIGHT_FETCH_RR_EN
                        owner_q <= win_idx;
`endif
                        if (len_arr[win_idx] == '0) begin
                            // Empty burst: report completion without touching the ROM.
                            done_q  <= win_onehot;
                            state_q <= StDone;
                        end else begin
                            grant_q       <= win_onehot;
                            rom_enable_q  <= 1'b1;
                            rom_address_q <= base_arr[win_idx];
                            state_q       <= StFetch;
                        end
                    end
                end

                StFetch: begin
                    rd_data_q     <= rom_data_i;
                    rd_valid_q    <= 1'b1;
                    rom_address_q <= rom_address_q + ADDRESS_BUS_WIDTH'(1);
                    cnt_q         <= cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        rd_last_q     <= 1'b1;
                        done_q        <= grant_q;
                        grant_q       <= '0;
                        rom_enable_q  <= 1'b0;
                        rom_address_q <= '0;
                        state_q       <= StDone;
                    end
                end

                StDone: begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                    done_q     <= '0;
                    state_q    <= StIdle;
`ifdef WEIGHT_FETCH_RR_EN
                    ptr_q      <= ptr_next;
`endif
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_last_o     = rd_last_q;
    assign done_o        = done_q;
    assign busy_o        = (state_q != StIdle);
    assign rom_address_o = rom_address_q;
    assign rom_enable_o  = rom_enable_q;

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Self-checking bench for weight_fetch_arbiter: directed cases plus randomized bursts checked
// cycle by cycle against a transaction-level model of the burst timeline.
module tb_weight_fetch_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned NR = 4;
    localparam int unsigned LW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_base;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic [NR-1:0]     done;
    logic              busy;
    logic [AW-1:0]     rom_address;
    logic              rom_enable;
    logic [DW-1:0]     rom_data;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m    = 0;

    logic [NR*AW-1:0]  bv;
    logic [NR*LW-1:0]  lv;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    assign rom_data = rom_word(rom_address);

    weight_fetch_arbiter #(
        .DATA_BUS_WIDTH   (DW),
        .ADDRESS_BUS_WIDTH(AW),
        .NUM_REQ          (NR),
        .LEN_WIDTH        (LW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .req_base_i   (req_base),
        .req_len_i    (req_len),
        .grant_o      (grant),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .rd_last_o    (rd_last),
        .done_o       (done),
        .busy_o       (busy),
        .rom_address_o(rom_address),
        .rom_enable_o (rom_enable),
        .rom_data_i   (rom_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [NR-1:0] g, input logic en,
                              input logic [AW-1:0] a, input logic v, input logic [DW-1:0] d,
                              input logic last, input logic [NR-1:0] dn, input logic b);
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".rom_enable"}, 32'(rom_enable), 32'(en));
        check_eq({tag, ".rom_address"}, 32'(rom_address), 32'(a));
        check_eq({tag, ".rd_valid"}, 32'(rd_valid), 32'(v));
        if (v) check_eq({tag, ".rd_data"}, 32'(rd_data), 32'(d));
        check_eq({tag, ".rd_last"}, 32'(rd_last), 32'(last));
        check_eq({tag, ".done"}, 32'(done), 32'(dn));
        check_eq({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Model arbitration: which requester the rules say wins for this request vector.
    function automatic int model_winner(input logic [NR-1:0] r);
`ifdef WEIGHT_FETCH_RR_EN
        for (int k = 0; k < int'(NR); k++) begin
            if (r[(ptr_m + k) % int'(NR)]) return (ptr_m + k) % int'(NR);
        end
`else
        for (int k = 0; k < int'(NR); k++) begin
            if (r[k]) return k;
        end
`endif
        return 0;
    endfunction

    // Called one step after an edge with the DUT idle. Drives a request set and checks the whole
    // burst timeline through the return to IDLE. With scramble set, base/len and the request
    // bits are disturbed during the burst, which must not change anything.
    task automatic run_burst(input string tag, input logic [NR-1:0] r,
                             input logic [NR*AW-1:0] bases, input logic [NR*LW-1:0] lens,
                             input bit scramble);
        int            w;
        int            len;
        logic [AW-1:0] b;
        logic [NR-1:0] oh;
        req      = r;
        req_base = bases;
        req_len  = lens;
        w   = model_winner(r);
        b   = bases[w*AW +: AW];
        len = int'(lens[w*LW +: LW]);
        oh  = NR'(1) << w;
        for (int t = 1; t <= len; t++) begin
            @(posedge clk); #1;
            expect_out({tag, ".fetch"}, oh, 1'b1, AW'(b + AW'(t - 1)), (t >= 2),
                       rom_word(AW'(b + AW'(t - 2))), 1'b0, '0, 1'b1);
            if (scramble) begin
                req_base = {$urandom, $urandom};
                req_len  = $urandom;
                if ($urandom_range(0, 3) == 0) req = NR'($urandom) & ~oh;
            end
        end
        @(posedge clk); #1;
        expect_out({tag, ".done"}, '0, 1'b0, '0, (len > 0), rom_word(AW'(b + AW'(len - 1))),
                   (len > 0), oh, 1'b1);
        ptr_m = (w + 1) % int'(NR);
        req   = '0;
        @(posedge clk); #1;
        expect_idle({tag, ".idle"});
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = NR'($urandom);
        req_base = {$urandom, $urandom};
        req_len  = $urandom;

        // Reset held with random requests
        repeat (3) begin
            @(posedge clk); #1;
            req = NR'($urandom) | NR'(1);
            expect_idle("reset");
        end
        req   = '0;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            expect_idle("post_reset");
        end

        // Single burst
        bv = {$urandom, $urandom}; lv = $urandom;
        bv[0*AW +: AW] = 16'h0010; lv[0*LW +: LW] = 8'd3;
        run_burst("single", 4'b0001, bv, lv, 1'b0);

        // Zero length
        bv = {$urandom, $urandom}; lv = $urandom;
        lv[2*LW +: LW] = 8'd0;
        run_burst("zero_len", 4'b0100, bv, lv, 1'b0);

        // Address wrap
        bv = {$urandom, $urandom}; lv = $urandom;
        bv[1*AW +: AW] = 16'hFFFE; lv[1*LW +: LW] = 8'd4;
        run_burst("wrap", 4'b0010, bv, lv, 1'b0);

        // Maximum length, wrapping, with disturbed inputs
        bv = {$urandom, $urandom}; lv = $urandom;
        bv[3*AW +: AW] = 16'hFF80; lv[3*LW +: LW] = 8'hFF;
        run_burst("max_len", 4'b1000, bv, lv, 1'b1);

        // Contention: all requesting continuously, every length 2
        bv = {$urandom, $urandom}; lv = {NR{8'd2}};
        for (int i = 0; i < 5; i++) run_burst("contend", 4'b1111, bv, lv, 1'b0);

        // Reset during word 2 of a length-5 burst
        bv = {$urandom, $urandom}; lv = $urandom;
        bv[0*AW +: AW] = 16'h0040; lv[0*LW +: LW] = 8'd5;
        req = 4'b0001; req_base = bv; req_len = lv;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_out("pre_abort", 4'b0001, 1'b1, 16'h0041, 1'b1, rom_word(16'h0040), 1'b0, '0, 1'b1);
        #2 rst_n = 1'b0;
        #1 expect_idle("abort_async");
        req = 4'b1111;
        repeat (3) begin
            @(posedge clk); #1;
            expect_idle("abort_hold");
        end
        req   = '0;
        rst_n = 1'b1;
        ptr_m = 0;
        @(posedge clk); #1;
        expect_idle("abort_release");
        bv = {$urandom, $urandom}; lv = {NR{8'd2}};
        run_burst("after_abort", 4'b1111, bv, lv, 1'b0);

        // Randomized bursts with occasional idle gaps
        for (int i = 0; i < 150; i++) begin
            bv = {$urandom, $urandom};
            for (int j = 0; j < int'(NR); j++) begin
                lv[j*LW +: LW] = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 255))
                                                             : LW'($urandom_range(0, 6));
            end
            run_burst("rand", NR'($urandom_range(1, 15)), bv, lv, ($urandom_range(0, 1) == 1));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk); #1;
                expect_idle("rand_gap");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
